// File: rtl/tdc_thermo_encoder_if.sv
// ---------------------------------------------------------------------------
// tdc_thermo_encoder_if
//   Bundles the TDC encoder's control, tap and timestamp signals.
//   master : the side that drives enable/tap_in and consumes timestamps
//   slave  : the encoder itself
//   Signals:
//     enable      - 1 = coarse counter runs and hits are reported
//     tap_in      - raw delay-line taps, bit 0 nearest the line input
//     hit_valid   - one-cycle strobe qualifying fine_code/coarse_time/saturated
//     fine_code   - leading-ones count of the bubble-corrected word
//     coarse_time - coarse counter value at the hit's sampling edge
//     saturated   - corrected word was all ones
//     coarse_wrap - one-cycle pulse when the coarse counter rolls over
// ---------------------------------------------------------------------------
interface tdc_thermo_encoder_if #(
  parameter int NTAP     = 32,
  parameter int FINE_W   = 6,
  parameter int COARSE_W = 16
);
  logic                enable;
  logic [NTAP-1:0]     tap_in;
  logic                hit_valid;
  logic [FINE_W-1:0]   fine_code;
  logic [COARSE_W-1:0] coarse_time;
  logic                saturated;
  logic                coarse_wrap;

  modport master (
    output enable,
    output tap_in,
    input  hit_valid,
    input  fine_code,
    input  coarse_time,
    input  saturated,
    input  coarse_wrap
  );

  modport slave (
    input  enable,
    input  tap_in,
    output hit_valid,
    output fine_code,
    output coarse_time,
    output saturated,
    output coarse_wrap
  );
endinterface

// File: rtl/tdc_thermo_encoder.sv
// ---------------------------------------------------------------------------
// tdc_thermo_encoder
//   Back end of the TDC delay line. Captures the tap vector every clock,
//   resynchronises it, removes single-tap bubbles, detects the rising edge
//   of the hit at tap 0 and emits one timestamp (fine + coarse) per hit.
//   Ports:
//     clk   - sampling clock, all flops rising-edge
//     rst_n - asynchronous active-low reset
//     bus   - slave side of tdc_thermo_encoder_if (enable, tap_in in;
//             hit_valid, fine_code, coarse_time, saturated, coarse_wrap out)
//   Pipeline (edge n captures tap_in):
//     S1 n   : capture taps, counter value, enable
//     S2 n+1 : metastability stage
//     S3 n+2 : bubble-corrected word and hit detect registered
//     S4 n+3 : timestamp registered, hit_valid strobes
// ---------------------------------------------------------------------------
module tdc_thermo_encoder #(
  parameter int NTAP     = 32,
  parameter int FINE_W   = 6,
  parameter int COARSE_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tdc_thermo_encoder_if.slave  bus
);

  // Majority of three: removes an isolated bubble in either polarity.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    maj3 = (a & b) | (a & c) | (b & c);
  endfunction

  // Index of the first 0 scanning up from bit 0; NTAP when all ones.
  // Scanning downwards lets the lowest zero overwrite any higher one.
  function automatic logic [FINE_W-1:0] first_zero(input logic [NTAP-1:0] v);
    first_zero = FINE_W'(NTAP);
    for (int k = NTAP - 1; k >= 0; k--) begin
      if (!v[k]) begin
        first_zero = FINE_W'(k);
      end else begin
        first_zero = first_zero;
      end
    end
  endfunction

  // Coarse counter
  logic [COARSE_W-1:0] r_cnt;
  logic                r_wrap;
  // S1
  logic [NTAP-1:0]     r_cap;
  logic [COARSE_W-1:0] r_cnt_s1;
  logic                r_en_s1;
  // S2
  logic [NTAP-1:0]     r_sync;
  logic [COARSE_W-1:0] r_cnt_s2;
  logic                r_en_s2;
  // S3
  logic [NTAP-1:0]     r_corr;
  logic                r_prev0;
  logic                r_hit;
  logic [COARSE_W-1:0] r_cnt_s3;
  // S4 / outputs
  logic                r_hit_valid;
  logic [FINE_W-1:0]   r_fine;
  logic [COARSE_W-1:0] r_coarse;
  logic                r_sat;

  // Synchronised word extended with its boundary values:
  // below tap 0 mirrors tap 0, above the last tap reads as 0.
  logic [NTAP+1:0]     w_ext;
  logic [NTAP-1:0]     w_corr;

  assign w_ext = {1'b0, r_sync, r_sync[0]};

  // Bubble correction: each corrected bit is the majority of its neighbourhood.
  always_comb begin
    w_corr = '0;
    for (int k = 0; k < NTAP; k++) begin
      w_corr[k] = maj3(w_ext[k], w_ext[k+1], w_ext[k+2]);
    end
  end

  // Free-running coarse counter, held at 0 while disabled; flags rollover.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_wrap <= 1'b0;
    end else if (bus.enable) begin
      r_cnt  <= r_cnt + COARSE_W'(1);
      r_wrap <= (r_cnt == {COARSE_W{1'b1}});
    end else begin
      r_cnt  <= '0;
      r_wrap <= 1'b0;
    end
  end

  // S1: capture taps with the counter value seen at this sampling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap    <= '0;
      r_cnt_s1 <= '0;
      r_en_s1  <= 1'b0;
    end else begin
      r_cap    <= bus.tap_in;
      r_cnt_s1 <= r_cnt;
      r_en_s1  <= bus.enable;
    end
  end

  // S2: second flop on the taps to settle metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '0;
      r_cnt_s2 <= '0;
      r_en_s2  <= 1'b0;
    end else begin
      r_sync   <= r_cap;
      r_cnt_s2 <= r_cnt_s1;
      r_en_s2  <= r_en_s1;
    end
  end

  // S3: register corrected word; a hit is a rising corr[0] qualified by the
  // enable that travelled with this sample. prev0 tracks even when disabled,
  // so a level already high when enable rises is not reported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_corr   <= '0;
      r_prev0  <= 1'b0;
      r_hit    <= 1'b0;
      r_cnt_s3 <= '0;
    end else begin
      r_corr   <= w_corr;
      r_prev0  <= w_corr[0];
      r_hit    <= w_corr[0] & ~r_prev0 & r_en_s2;
      r_cnt_s3 <= r_cnt_s2;
    end
  end

  // S4: encode the timestamp on a hit; otherwise hold the last timestamp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_valid <= 1'b0;
      r_fine      <= '0;
      r_coarse    <= '0;
      r_sat       <= 1'b0;
    end else begin
      r_hit_valid <= r_hit;
      if (r_hit) begin
        r_fine   <= first_zero(r_corr);
        r_coarse <= r_cnt_s3;
        r_sat    <= &r_corr;
      end
    end
  end

  assign bus.hit_valid   = r_hit_valid;
  assign bus.fine_code   = r_fine;
  assign bus.coarse_time = r_coarse;
  assign bus.saturated   = r_sat;
  assign bus.coarse_wrap = r_wrap;

endmodule
